binary_to_gray_reg: RTL and testbench
=====================================

Name: binary_to_gray_reg

Overview:
Parameterised binary-to-Gray code converter with a registered output and a valid qualifier.
Used wherever a counter value must cross a clock domain or drive a single-bit-change encoder, e.g. FIFO pointers and position encoders.
Also provides the inverse Gray-to-binary conversion, selected per transfer, so one block serves both ends of a pointer-synchronisation path.

Parameters:
WIDTH, 8, data width in bits; legal range 2..64.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
in_valid  input  1  qualifies data_in and mode for one cycle.
mode  input  1  0 = binary-to-Gray, 1 = Gray-to-binary.
data_in  input  WIDTH  operand (binary when mode=0, Gray when mode=1).
data_out  output  WIDTH  registered conversion result.
out_valid  output  1  high for exactly one cycle per accepted input.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset: on a rising edge with rst=1, data_out = 0 and out_valid = 0. Reset overrides in_valid.
- Reset mid-stream: any conversion in flight is discarded, with no out_valid pulse for it. The first valid input after rst deasserts is processed normally.
- Latency: exactly 1 cycle. An input accepted on edge N appears on data_out, with out_valid=1, after edge N.
- Throughput: one conversion per cycle. Back-to-back in_valid is allowed; there is no backpressure (no ready signal).
- Hold: when in_valid=0, data_out holds its last value and out_valid=0 on the next cycle.
- mode=0, binary to Gray: g[WIDTH-1] = b[WIDTH-1]; g[i] = b[i+1] XOR b[i] for i < WIDTH-1. Equivalently, g = b XOR (b >> 1) with a logical shift.
- mode=1, Gray to binary: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] XOR g[i], computed MSB to LSB. This is a purely combinational prefix-XOR; no iteration over cycles.
- Both directions are purely combinational before the output register, with no state carried between transfers.
- Boundary cases:
  - Input 0 maps to 0 in both modes.
  - All-ones binary maps to MSB-only Gray (e.g. 0xFF to 0x80 at WIDTH=8), and the inverse holds.
  - The sequence of Gray outputs for binary inputs 0..2^WIDTH-1 changes exactly one bit between consecutive codes, including the wrap from 2^WIDTH-1 back to 0.
- No X propagation: data_out is always a defined value after reset.

Decomposition:
- Shared package holds:
  - function bin2gray(logic [WIDTH-1:0]) and function gray2bin(logic [WIDTH-1:0]), parameterised by width through a macro or parameterised class.
  - localparam MODE_B2G = 1'b0 and MODE_G2B = 1'b1.
- One natural combinational sub-module, gray_to_binary_comb, implementing the prefix-XOR. It is reusable by pointer synchronisers.
- The binary-to-Gray direction stays inline (a single XOR).

Test Plan:
- Reset: hold rst=1 for 10 cycles with in_valid toggling -> data_out=0x00 and out_valid=0 throughout.
- Sweep, mode=0, WIDTH=8: apply binary 0x00..0xFF back-to-back, one per cycle -> each result equals b^(b>>1) one cycle later. Spot checks: 0x01->0x01, 0x02->0x03, 0x05->0x07, 0x7F->0x40, 0x80->0xC0, 0xFF->0x80.
- Single-bit-change property: across the same sweep plus the wrap 0xFF->0x00 -> the popcount of the XOR of consecutive data_out values is 1 every time (including 0x80->0x00).
- Inverse, mode=1: apply Gray 0x00, 0x03, 0x07, 0xC0, 0x80 -> outputs 0x00, 0x02, 0x05, 0x80, 0xFF. Round trip: the G2B result of the B2G result equals the original for all 256 values.
- Hold and valid gaps: drive 0x0A then drop in_valid for 3 cycles -> data_out stays 0x0F and out_valid is high for one cycle only.
- Reset mid-stream: assert rst in the same cycle as in_valid with 0x33 -> no out_valid pulse and data_out=0. The next valid input 0x33 then gives 0x2A.

Source files
------------

// File: rtl/binary_to_gray_reg_pkg.sv
// Shared Gray-code helpers and mode encodings for the binary/Gray converter family.
// Width is carried by the class parameter so one definition serves every pointer width.
package binary_to_gray_reg_pkg;

   localparam logic MODE_B2G = 1'b0;
   localparam logic MODE_G2B = 1'b1;

   virtual class gray_fn #(parameter int W = 8);

      static function logic [W-1:0] bin2gray(input logic [W-1:0] b);
         return b ^ (b >> 1);
      endfunction

      // Prefix XOR from the MSB down: each binary bit folds in every Gray bit above it.
      static function logic [W-1:0] gray2bin(input logic [W-1:0] g);
         logic [W-1:0] b;
         b[W-1] = g[W-1];
         for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
         end
         return b;
      endfunction

   endclass

endpackage

// File: rtl/binary_to_gray_reg_gray_to_binary_comb.sv
// Combinational Gray-to-binary decoder, reusable on the receive side of pointer synchronisers.
module gray_to_binary_comb
   import binary_to_gray_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] gray_i,
   output logic [WIDTH-1:0] bin_o
);

   always_comb begin
      bin_o = gray_fn#(WIDTH)::gray2bin(gray_i);
   end

endmodule

// File: rtl/binary_to_gray_reg.sv
// Registered binary<->Gray converter: one conversion per cycle, one cycle of latency,
// direction chosen per transfer by mode.
module binary_to_gray_reg
   import binary_to_gray_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             mode,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid
);

   // Handshake: in_valid qualifies mode/data_in for the single cycle it is high and is
   // always accepted (no ready). out_valid pulses exactly one cycle later per accepted input.

   logic [WIDTH-1:0] g2b_w;
   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] data_q;
   logic             valid_d;
   logic             valid_q;

   gray_to_binary_comb #(
      .WIDTH (WIDTH)
   ) u_g2b (
      .gray_i (data_in),
      .bin_o  (g2b_w)
   );

   always_comb begin
      data_d  = data_q;
      valid_d = in_valid;
      if (in_valid) begin
         data_d = (mode == MODE_G2B) ? g2b_w : gray_fn#(WIDTH)::bin2gray(data_in);
      end
   end

   // Reset wins over a same-cycle in_valid, so an in-flight conversion never surfaces.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_out  = data_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_binary_to_gray_reg.sv
// Directed bench for binary_to_gray_reg at WIDTH=8: reset, sweep, vector table,
// round trip, hold and mid-stream reset.
module tb_binary_to_gray_reg;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         mode;
   logic [W-1:0] data_in;
   logic [W-1:0] data_out;
   logic         out_valid;

   int n_checks = 0;
   int n_fail   = 0;

   binary_to_gray_reg #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .mode      (mode),
      .data_in   (data_in),
      .data_out  (data_out),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         mode;
      logic [W-1:0] din;
      logic [W-1:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled on the next falling edge.
   task automatic drive(input logic v, input logic m, input logic [W-1:0] d);
      in_valid = v;
      mode     = m;
      data_in  = d;
      @(negedge clk);
   endtask

   initial begin
      logic [W-1:0] prev;
      logic [W-1:0] g;

      rst      = 1'b1;
      in_valid = 1'b0;
      mode     = 1'b0;
      data_in  = '0;
      @(negedge clk);

      // Reset held with in_valid toggling: outputs stay cleared.
      for (int i = 0; i < 10; i++) begin
         drive(~in_valid, 1'($urandom_range(0, 1)), W'($urandom_range(1, 255)));
         check("reset_data", data_out, 8'h00);
         check("reset_valid", {7'b0, out_valid}, 8'h00);
      end
      rst = 1'b0;
      drive(1'b0, 1'b0, 8'h00);
      check("post_reset_valid", {7'b0, out_valid}, 8'h00);

      // Back-to-back binary sweep, with the single-bit-change property including the wrap.
      for (int b = 0; b < 256; b++) begin
         drive(1'b1, 1'b0, W'(b));
         check("sweep_data", data_out, W'(b) ^ (W'(b) >> 1));
         check("sweep_valid", {7'b0, out_valid}, 8'h01);
         if (b > 0) check("sweep_onebit", 8'($countones(prev ^ data_out)), 8'h01);
         prev = data_out;
      end
      drive(1'b1, 1'b0, 8'h00);
      check("wrap_data", data_out, 8'h00);
      check("wrap_onebit", 8'($countones(prev ^ data_out)), 8'h01);

      // Hand-computed vectors for both directions.
      vecs.push_back('{1'b0, 8'h00, 8'h00});
      vecs.push_back('{1'b0, 8'h01, 8'h01});
      vecs.push_back('{1'b0, 8'h02, 8'h03});
      vecs.push_back('{1'b0, 8'h05, 8'h07});
      vecs.push_back('{1'b0, 8'h7F, 8'h40});
      vecs.push_back('{1'b0, 8'h80, 8'hC0});
      vecs.push_back('{1'b0, 8'hFF, 8'h80});
      vecs.push_back('{1'b0, 8'hAA, 8'hFF});
      vecs.push_back('{1'b1, 8'h00, 8'h00});
      vecs.push_back('{1'b1, 8'h03, 8'h02});
      vecs.push_back('{1'b1, 8'h07, 8'h05});
      vecs.push_back('{1'b1, 8'hC0, 8'h80});
      vecs.push_back('{1'b1, 8'h80, 8'hFF});
      vecs.push_back('{1'b1, 8'hFF, 8'hAA});
      vecs.push_back('{1'b1, 8'h40, 8'h7F});
      for (int i = 0; i < vecs.size(); i++) begin
         drive(1'b1, vecs[i].mode, vecs[i].din);
         check($sformatf("vec%0d_data", i), data_out, vecs[i].exp);
         check($sformatf("vec%0d_valid", i), {7'b0, out_valid}, 8'h01);
      end

      // Round trip: B2G then G2B restores every value.
      for (int v = 0; v < 256; v++) begin
         drive(1'b1, 1'b0, W'(v));
         g = data_out;
         drive(1'b1, 1'b1, g);
         check("roundtrip", data_out, W'(v));
      end

      // Valid gap: result holds, out_valid pulses once.
      drive(1'b1, 1'b0, 8'h0A);
      check("hold_first", data_out, 8'h0F);
      check("hold_first_valid", {7'b0, out_valid}, 8'h01);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, W'($urandom_range(0, 255)));
         check("hold_data", data_out, 8'h0F);
         check("hold_valid", {7'b0, out_valid}, 8'h00);
      end

      // Reset coinciding with a valid input discards it.
      rst = 1'b1;
      drive(1'b1, 1'b0, 8'h33);
      check("midrst_data", data_out, 8'h00);
      check("midrst_valid", {7'b0, out_valid}, 8'h00);
      rst = 1'b0;
      drive(1'b1, 1'b0, 8'h33);
      check("after_rst_data", data_out, 8'h2A);
      check("after_rst_valid", {7'b0, out_valid}, 8'h01);
      drive(1'b0, 1'b0, 8'h00);
      check("after_rst_idle_valid", {7'b0, out_valid}, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
